// File: rtl/tdm_slot_master_pkg.sv
// Shared types and constants for the TDM slot master and its request FIFO.
package tdm_slot_master_pkg;

    localparam int SLOT_W     = 3;
    localparam int SLOT_N     = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // Slot one cycle before `id`, modulo the rotation length.
    function automatic logic [SLOT_W-1:0] prev_slot(input int id);
        return SLOT_W'(id + SLOT_N - 1);
    endfunction

endpackage

// File: rtl/tdm_req_fifo.sv
// Synchronous request FIFO with extra-MSB pointers for full/empty detection.
module tdm_req_fifo
    import tdm_slot_master_pkg::*;
#(
    parameter int W     = 25,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_full;
    logic         w_empty;
    logic         w_push;
    logic         w_pop;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !w_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

    assign o_dout  = r_mem[r_rptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/tdm_slot_master.sv
// One bus master on a TDM schedule: queues requests and drives the bus in its own slot.
// Define TDM_RETRY_LIMIT_EN to drop a request after MAX_RETRY missed retries.
module tdm_slot_master
    import tdm_slot_master_pkg::*;
#(
    parameter int SLOT_ID   = 0,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SLOT_W-1:0] slot,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              rsp_valid,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam logic [SLOT_W-1:0] ARM_SLOT = prev_slot(SLOT_ID);

    if (SLOT_ID < 0 || SLOT_ID >= SLOT_N || MAX_RETRY < 1 || DEPTH < 2)
    begin : g_bad_param
        $error("tdm_slot_master: illegal parameter value");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_arm;
    logic              w_done;
    logic              w_drop;
    logic [ENT_W-1:0]  w_head;
    logic              w_head_we;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_wdata;

    logic              r_bus_req;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic              r_rsp_valid;
    logic              r_rsp_we;
    logic [DATA_W-1:0] r_rsp_rdata;

    assign w_push = req_valid && !w_full;
    assign w_pop  = w_done || w_drop;

    tdm_req_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   ({req_we, req_addr, req_wdata}),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_we    = w_head[ENT_W-1];
    assign w_head_addr  = w_head[ENT_W-2 -: ADDR_W];
    assign w_head_wdata = w_head[DATA_W-1:0];

`ifdef TDM_RETRY_LIMIT_EN
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    logic [RETRY_W-1:0] r_retry;
    logic               r_rsp_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retry <= '0;
        end else if (w_pop) begin
            r_retry <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_retry <= r_retry + RETRY_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rsp_err <= 1'b0;
        else      r_rsp_err <= w_drop;
    end

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_arm       = 1'b0;
        w_done      = 1'b0;
        w_drop      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty && slot == ARM_SLOT) begin
                    w_state_nxt = ST_ISSUE;
                    w_arm       = 1'b1;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_IDLE;
                if (bus_ack) begin
                    w_done = 1'b1;
                end
`ifdef TDM_RETRY_LIMIT_EN
                else if (r_retry == RETRY_W'(MAX_RETRY)) begin
                    w_drop = 1'b1;
                end
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Bus fields are loaded one cycle early so they appear exactly in the own slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else begin
            r_bus_req   <= w_arm;
            r_bus_we    <= w_arm && w_head_we;
            r_bus_addr  <= w_arm ? w_head_addr : '0;
            r_bus_wdata <= w_arm ? w_head_wdata : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_pop;
            r_rsp_we    <= w_pop && r_bus_we;
            r_rsp_rdata <= (w_done && !r_bus_we) ? bus_rdata : '0;
        end
    end

    assign req_ready = !w_full;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_we    = r_rsp_we;
    assign rsp_rdata = r_rsp_rdata;

endmodule
